// File: rtl/dc_pkg.sv
// Shared types and default widths for the DC launch sequencer slice.
package dc_pkg;

   localparam int DAC_CHANNEL_DEF = 24;
   localparam int CNT_WIDTH_DEF   = 32;
   localparam int REP_WIDTH_DEF   = 16;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WAIT_ARM = 3'd1,
      ST_DELAY    = 3'd2,
      ST_FIRE     = 3'd3,
      ST_PERIOD   = 3'd4,
      ST_DONE     = 3'd5,
      ST_ERR      = 3'd6
   } state_t;

endpackage

// File: rtl/dc_launch_seq_if.sv
// Command/status bundle of the launch sequencer; master drives commands, slave is the sequencer.
interface dc_launch_seq_if
   import dc_pkg::*;
#(
   parameter int DAC_CHANNEL = DAC_CHANNEL_DEF,
   parameter int CNT_WIDTH   = CNT_WIDTH_DEF,
   parameter int REP_WIDTH   = REP_WIDTH_DEF
);

   logic                   cmd_valid;
   logic                   cmd_ready;
   logic [DAC_CHANNEL-1:0] cmd_mask;
   logic [CNT_WIDTH-1:0]   cmd_delay;
   logic [CNT_WIDTH-1:0]   cmd_period;
   logic [REP_WIDTH-1:0]   cmd_repeat;
   logic                   abort;
   logic [DAC_CHANNEL-1:0] armed;
   logic [DAC_CHANNEL-1:0] start;
   logic                   busy;
   logic                   done;
   logic                   err_timeout;
   logic [REP_WIDTH-1:0]   fire_cnt;

   modport master (
      output cmd_valid, cmd_mask, cmd_delay, cmd_period, cmd_repeat, abort, armed,
      input  cmd_ready, start, busy, done, err_timeout, fire_cnt
   );

   modport slave (
      input  cmd_valid, cmd_mask, cmd_delay, cmd_period, cmd_repeat, abort, armed,
      output cmd_ready, start, busy, done, err_timeout, fire_cnt
   );

endinterface

// File: rtl/cycle_timer.sv
// Loadable down-counter; load wins over enable, o_zero flags a count of zero.
module cycle_timer #(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_load,
   input  logic [CNT_WIDTH-1:0] i_load_val,
   input  logic                 i_en,
   output logic                 o_zero
);

   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (i_load) begin
         cnt_d = i_load_val;
      end else if (i_en) begin
         cnt_d = cnt_q - CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign o_zero = (cnt_q == '0);

endmodule

// File: rtl/dc_launch_seq.sv
// Launch sequencer: waits for the masked DC channels to arm, then issues delayed,
// repeated one-cycle start pulses.
module dc_launch_seq
   import dc_pkg::*;
#(
   parameter int DAC_CHANNEL = DAC_CHANNEL_DEF,
   parameter int CNT_WIDTH   = CNT_WIDTH_DEF,
   parameter int REP_WIDTH   = REP_WIDTH_DEF,
   parameter int ARM_TIMEOUT = 1000000
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   // Handshake: a command transfers on a rising edge where i_cmd_valid && o_cmd_ready;
   // o_cmd_ready is high only in IDLE and never depends on i_cmd_valid.
   input  logic                   i_cmd_valid,
   output logic                   o_cmd_ready,
   input  logic [DAC_CHANNEL-1:0] i_cmd_mask,
   input  logic [CNT_WIDTH-1:0]   i_cmd_delay,
   input  logic [CNT_WIDTH-1:0]   i_cmd_period,
   input  logic [REP_WIDTH-1:0]   i_cmd_repeat,
   input  logic                   i_abort,
   input  logic [DAC_CHANNEL-1:0] i_armed,
   output logic [DAC_CHANNEL-1:0] o_start,
   output logic                   o_busy,
   output logic                   o_done,
   output logic                   o_err_timeout,
   output logic [REP_WIDTH-1:0]   o_fire_cnt,
   output state_t                 o_dbg_state
);

   localparam logic [CNT_WIDTH-1:0] TMO_LOAD = CNT_WIDTH'(ARM_TIMEOUT - 1);

   state_t                 state_q, state_d;
   logic [DAC_CHANNEL-1:0] mask_q, mask_d;
   logic [CNT_WIDTH-1:0]   delay_q, delay_d;
   logic [CNT_WIDTH-1:0]   period_q, period_d;
   logic [REP_WIDTH-1:0]   rep_q, rep_d;
   logic [REP_WIDTH-1:0]   fire_cnt_q, fire_cnt_d;
   logic                   err_q, err_d;
   logic                   rdy_q;

   logic                   tmr_load, tmr_en, tmr_zero;
   logic [CNT_WIDTH-1:0]   tmr_val;
   logic                   accept, armed_ok;
   logic [REP_WIDTH-1:0]   eff_rep, fire_nxt;

   assign o_cmd_ready = (state_q == ST_IDLE) && rdy_q;
   assign accept      = i_cmd_valid && o_cmd_ready;
   assign armed_ok    = ((i_armed & mask_q) == mask_q);
   assign eff_rep     = (rep_q == '0) ? REP_WIDTH'(1) : rep_q;
   assign fire_nxt    = fire_cnt_q + REP_WIDTH'(1);

   // One timer serves the arm timeout, the initial delay and the inter-fire period;
   // each is loaded with N-1 so the owning state lasts exactly N cycles.
   cycle_timer #(
      .CNT_WIDTH(CNT_WIDTH)
   ) u_timer (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_load     (tmr_load),
      .i_load_val (tmr_val),
      .i_en       (tmr_en),
      .o_zero     (tmr_zero)
   );

   always_comb begin
      state_d    = state_q;
      mask_d     = mask_q;
      delay_d    = delay_q;
      period_d   = period_q;
      rep_d      = rep_q;
      fire_cnt_d = fire_cnt_q;
      err_d      = err_q;
      tmr_load   = 1'b0;
      tmr_val    = TMO_LOAD;
      tmr_en     = 1'b0;
      o_start    = '0;
      o_done     = 1'b0;

      if (state_q != ST_IDLE && i_abort) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  mask_d     = i_cmd_mask;
                  delay_d    = i_cmd_delay;
                  period_d   = i_cmd_period;
                  rep_d      = i_cmd_repeat;
                  fire_cnt_d = '0;
                  err_d      = 1'b0;
                  if (i_cmd_mask == '0) begin
                     state_d = ST_DONE;
                  end else begin
                     state_d  = ST_WAIT_ARM;
                     tmr_load = 1'b1;
                  end
               end
            end
            ST_WAIT_ARM: begin
               if (armed_ok) begin
                  // The delay belongs to the first fire only.
                  if (fire_cnt_q == '0 && delay_q != '0) begin
                     state_d  = ST_DELAY;
                     tmr_load = 1'b1;
                     tmr_val  = delay_q - CNT_WIDTH'(1);
                  end else begin
                     state_d = ST_FIRE;
                  end
               end else if (tmr_zero) begin
                  state_d = ST_ERR;
               end else begin
                  tmr_en = 1'b1;
               end
            end
            ST_DELAY: begin
               if (tmr_zero) begin
                  state_d = ST_FIRE;
               end else begin
                  tmr_en = 1'b1;
               end
            end
            ST_FIRE: begin
               o_start    = mask_q;
               fire_cnt_d = fire_nxt;
               if (fire_nxt == eff_rep) begin
                  state_d = ST_DONE;
               end else if (period_q == '0) begin
                  state_d  = ST_WAIT_ARM;
                  tmr_load = 1'b1;
               end else begin
                  state_d  = ST_PERIOD;
                  tmr_load = 1'b1;
                  tmr_val  = period_q - CNT_WIDTH'(1);
               end
            end
            ST_PERIOD: begin
               if (tmr_zero) begin
                  state_d  = ST_WAIT_ARM;
                  tmr_load = 1'b1;
               end else begin
                  tmr_en = 1'b1;
               end
            end
            ST_DONE: begin
               o_done  = 1'b1;
               state_d = ST_IDLE;
            end
            ST_ERR: begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q    <= ST_IDLE;
         mask_q     <= '0;
         delay_q    <= '0;
         period_q   <= '0;
         rep_q      <= '0;
         fire_cnt_q <= '0;
         err_q      <= 1'b0;
         rdy_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         mask_q     <= mask_d;
         delay_q    <= delay_d;
         period_q   <= period_d;
         rep_q      <= rep_d;
         fire_cnt_q <= fire_cnt_d;
         err_q      <= err_d;
         rdy_q      <= 1'b1;
      end
   end

   assign o_busy        = (state_q != ST_IDLE);
   assign o_err_timeout = err_q;
   assign o_fire_cnt    = fire_cnt_q;
   assign o_dbg_state   = state_q;

endmodule

// File: tb/tb_dc_launch_seq.sv
// Self-checking bench for dc_launch_seq: start/done events are scored against an expected queue.
module tb_dc_launch_seq;
   import dc_pkg::*;

   localparam int DC  = 24;
   localparam int CW  = 32;
   localparam int RW  = 16;
   localparam int TMO = 100;

   logic   clk;
   logic   rst_n;
   state_t dbg_state;
   int     cyc;
   int     n_checks;
   int     n_err;

   // {cycle[31:0], mask[23:0]} of each expected start pulse; cycle of each expected done
   logic [55:0] exp_q[$];
   logic [31:0] done_q[$];
   logic [55:0] mon_e;
   logic [31:0] mon_d;

   dc_launch_seq_if #(.DAC_CHANNEL(DC), .CNT_WIDTH(CW), .REP_WIDTH(RW)) bus ();

   dc_launch_seq #(
      .DAC_CHANNEL(DC), .CNT_WIDTH(CW), .REP_WIDTH(RW), .ARM_TIMEOUT(TMO)
   ) dut (
      .i_clk         (clk),
      .i_rst         (rst_n),
      .i_cmd_valid   (bus.cmd_valid),
      .o_cmd_ready   (bus.cmd_ready),
      .i_cmd_mask    (bus.cmd_mask),
      .i_cmd_delay   (bus.cmd_delay),
      .i_cmd_period  (bus.cmd_period),
      .i_cmd_repeat  (bus.cmd_repeat),
      .i_abort       (bus.abort),
      .i_armed       (bus.armed),
      .o_start       (bus.start),
      .o_busy        (bus.busy),
      .o_done        (bus.done),
      .o_err_timeout (bus.err_timeout),
      .o_fire_cnt    (bus.fire_cnt),
      .o_dbg_state   (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
      $fatal(1, "watchdog");
   end

   // ---------------- checker ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (rst_n) begin
         if (exp_q.size() > 0 && exp_q[0][55:24] < 32'(cyc)) begin
            mon_e = exp_q.pop_front();
            check("missing_start", 32'(cyc), mon_e[55:24]);
         end
         if (done_q.size() > 0 && done_q[0] < 32'(cyc)) begin
            mon_d = done_q.pop_front();
            check("missing_done", 32'(cyc), mon_d);
         end
         if (bus.start != '0) begin
            if (exp_q.size() == 0) begin
               check("unexpected_start", 32'(bus.start), 32'd0);
            end else begin
               mon_e = exp_q.pop_front();
               check("start_cycle", 32'(cyc), mon_e[55:24]);
               check("start_mask", 32'(bus.start), 32'(mon_e[23:0]));
            end
         end
         if (bus.done) begin
            if (done_q.size() == 0) begin
               check("unexpected_done", 32'(bus.done), 32'd0);
            end else begin
               mon_d = done_q.pop_front();
               check("done_cycle", 32'(cyc), mon_d);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Expected timeline for a command with all masked channels armed throughout.
   task automatic plan(input int acc, input logic [23:0] m, input int d, input int p, input int r);
      int eff;
      int t;
      eff = (r == 0) ? 1 : r;
      if (m == '0) begin
         done_q.push_back(32'(acc + 1));
      end else begin
         t = acc + 2 + d;
         for (int k = 0; k < eff; k++) begin
            exp_q.push_back({32'(t), m});
            if (k < eff - 1) t = t + p + 2;
         end
         done_q.push_back(32'(t + 1));
      end
   endtask

   // Called at a negedge; returns at the negedge of the cycle after the accept cycle.
   task automatic send_cmd(input logic [23:0] m, input int d, input int p, input int r,
                           input bit auto_plan, output int acc);
      int guard;
      guard = 0;
      while (!bus.cmd_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      check("cmd_ready_wait", 32'(bus.cmd_ready), 32'd1);
      bus.cmd_mask   = m;
      bus.cmd_delay  = 32'(d);
      bus.cmd_period = 32'(p);
      bus.cmd_repeat = 16'(r);
      bus.cmd_valid  = 1'b1;
      acc = cyc;
      if (auto_plan) plan(acc, m, d, p, r);
      @(negedge clk);
      bus.cmd_valid  = 1'b0;
      // Garbage on the command fields must not disturb a latched command.
      bus.cmd_mask   = 24'($urandom());
      bus.cmd_delay  = $urandom();
      bus.cmd_period = $urandom();
      bus.cmd_repeat = 16'($urandom());
   endtask

   task automatic wait_idle(input int bound);
      int g;
      g = 0;
      while (bus.busy && g < bound) begin
         @(negedge clk);
         g++;
      end
      check("idle_reached", 32'(bus.busy), 32'd0);
   endtask

   task automatic wait_cyc(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int          acc;
      int          a_cyc;
      int          b_cyc;
      logic [23:0] m;
      int          d, p, r;

      n_checks = 0;
      n_err    = 0;
      rst_n          = 1'b0;
      bus.cmd_valid  = 1'b0;
      bus.cmd_mask   = '0;
      bus.cmd_delay  = '0;
      bus.cmd_period = '0;
      bus.cmd_repeat = '0;
      bus.abort      = 1'b0;
      bus.armed      = '1;

      repeat (2) @(negedge clk);
      check("rst_ready", 32'(bus.cmd_ready), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_start", 32'(bus.start), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_err", 32'(bus.err_timeout), 32'd0);
      check("rst_fire_cnt", 32'(bus.fire_cnt), 32'd0);
      check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_rst", 32'(bus.cmd_ready), 32'd1);

      // Two channels, no delay, single fire: accept at 10, start at 12, done at 13.
      wait_cyc(10);
      send_cmd(24'h000003, 0, 0, 1, 1'b1, acc);
      wait_idle(50);
      check("fire_cnt_single", 32'(bus.fire_cnt), 32'd1);

      // Delay 5, period 3, three fires: starts at N+7, N+12, N+17.
      send_cmd(24'h000001, 5, 3, 3, 1'b1, acc);
      wait_idle(100);
      check("fire_cnt_three", 32'(bus.fire_cnt), 32'd3);

      // Repeat 0 behaves as one fire; period 0 gives back-to-back spacing of 2.
      send_cmd(24'h00F0F0, 0, 0, 0, 1'b1, acc);
      wait_idle(50);
      check("fire_cnt_rep0", 32'(bus.fire_cnt), 32'd1);
      send_cmd(24'h000005, 2, 0, 3, 1'b1, acc);
      wait_idle(50);
      check("fire_cnt_p0", 32'(bus.fire_cnt), 32'd3);

      for (int i = 0; i < 4; i++) begin
         m = 24'($urandom_range(24'hFFFFFF, 1));
         d = $urandom_range(4, 0);
         p = $urandom_range(3, 0);
         r = $urandom_range(3, 0);
         send_cmd(m, d, p, r, 1'b1, acc);
         wait_idle(200);
         check("fire_cnt_rand", 32'(bus.fire_cnt), 32'((r == 0) ? 1 : r));
      end

      // Channel 23 never arms: 100 WAIT_ARM cycles, then ERR, then IDLE with the flag set.
      bus.armed = 24'h7FFFFF;
      send_cmd(24'h800000, 0, 0, 1, 1'b0, acc);
      wait_cyc(acc + 100);
      check("tmo_still_waiting", 32'(dbg_state), 32'(ST_WAIT_ARM));
      check("tmo_err_early", 32'(bus.err_timeout), 32'd0);
      wait_cyc(acc + 101);
      check("tmo_err_state", 32'(dbg_state), 32'(ST_ERR));
      check("tmo_no_done", 32'(bus.done), 32'd0);
      wait_cyc(acc + 102);
      check("tmo_err_flag", 32'(bus.err_timeout), 32'd1);
      check("tmo_idle", 32'(bus.busy), 32'd0);

      // Zero mask: straight to DONE, no start; the accept also clears the error flag.
      bus.armed = '1;
      send_cmd(24'h000000, 0, 0, 5, 1'b1, acc);
      check("err_cleared", 32'(bus.err_timeout), 32'd0);
      wait_idle(20);
      check("fire_cnt_mask0", 32'(bus.fire_cnt), 32'd0);

      // Two arm waits of ~60 cycles each: the timeout restarts on each WAIT_ARM entry.
      bus.armed = '0;
      send_cmd(24'h000001, 0, 0, 2, 1'b0, acc);
      a_cyc = acc + 60;
      wait_cyc(a_cyc);
      bus.armed = '1;
      exp_q.push_back({32'(a_cyc + 1), 24'h000001});
      wait_cyc(a_cyc + 1);
      bus.armed = '0;
      b_cyc = a_cyc + 62;
      wait_cyc(b_cyc);
      bus.armed = '1;
      exp_q.push_back({32'(b_cyc + 1), 24'h000001});
      done_q.push_back(32'(b_cyc + 2));
      wait_idle(20);
      check("rearm_fire_cnt", 32'(bus.fire_cnt), 32'd2);
      check("rearm_no_err", 32'(bus.err_timeout), 32'd0);

      // Abort raised during the FIRE cycle suppresses the pulse and returns to IDLE.
      send_cmd(24'h000001, 3, 0, 1, 1'b0, acc);
      wait_cyc(acc + 4);
      @(posedge clk);
      #1 bus.abort = 1'b1;
      @(negedge clk);
      check("abort_in_fire", 32'(dbg_state), 32'(ST_FIRE));
      check("abort_no_start", 32'(bus.start), 32'd0);
      check("abort_no_done", 32'(bus.done), 32'd0);
      @(posedge clk);
      #1 bus.abort = 1'b0;
      @(negedge clk);
      check("abort_idle", 32'(dbg_state), 32'(ST_IDLE));
      check("abort_fire_cnt", 32'(bus.fire_cnt), 32'd0);

      // Reset in PERIOD of a four-fire command: only the first start may appear.
      send_cmd(24'h000003, 0, 6, 4, 1'b0, acc);
      exp_q.push_back({32'(acc + 2), 24'h000003});
      wait_cyc(acc + 5);
      check("rst_mid_period", 32'(dbg_state), 32'(ST_PERIOD));
      rst_n = 1'b0;
      #1;
      check("midrst_start", 32'(bus.start), 32'd0);
      check("midrst_busy", 32'(bus.busy), 32'd0);
      check("midrst_done", 32'(bus.done), 32'd0);
      check("midrst_fire_cnt", 32'(bus.fire_cnt), 32'd0);
      check("midrst_ready", 32'(bus.cmd_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("midrst_ready_after", 32'(bus.cmd_ready), 32'd1);
      check("midrst_idle_after", 32'(bus.busy), 32'd0);
      repeat (20) @(negedge clk);

      check("exp_q_empty", 32'(exp_q.size()), 32'd0);
      check("done_q_empty", 32'(done_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
